// File: rtl/bht_flush_sweep_pkg.sv
// Shared types and helpers for the branch history table.
// Counter entries, update/prediction records and FSM states.
package bht_flush_sweep_pkg;

    localparam int unsigned VLEN = 64;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] sat;
    } bht_entry_t;

    typedef enum logic {
        BHT_IDLE,
        BHT_SWEEP
    } bht_state_e;

    // 2-bit saturating counter step.
    function automatic logic [1:0] bht_sat_next(input logic [1:0] sat, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (sat == 2'b11) ? 2'b11 : sat + 2'b01;
        end else begin
            nxt = (sat == 2'b00) ? 2'b00 : sat - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_flush_sweep.sv
// Branch history table of 2-bit counters with registered lookup and a
// row-per-cycle flush sweep FSM.
module bht_flush_sweep
    import bht_flush_sweep_pkg::*;
#(
    parameter int unsigned NR_ENTRIES      = 128,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned VLEN            = bht_flush_sweep_pkg::VLEN
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic [VLEN-1:0]            vpc_i,
    input  logic                       upd_valid_i,
    input  logic [VLEN-1:0]            upd_pc_i,
    input  logic                       upd_taken_i,
    output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
    output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
    output logic                       flush_busy_o
);

    localparam int unsigned NR_ROWS  = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned ROW_BITS = $clog2(NR_ROWS);

    bht_entry_t      table_q [NR_ROWS][INSTR_PER_FETCH];
    bht_prediction_t pred_q  [INSTR_PER_FETCH];
    bht_prediction_t pred_d  [INSTR_PER_FETCH];
    bht_state_e      state_q, state_d;
    logic [ROW_BITS-1:0] cnt_q, cnt_d;

    bht_update_t         upd;
    logic [ROW_BITS-1:0] upd_row;
    logic                upd_col;
    logic                upd_en;
    logic [ROW_BITS-1:0] lk_row;
    bht_entry_t          entry_d;
    logic                unused_bits;

    always_comb begin
        upd.valid = upd_valid_i;
        upd.pc    = upd_pc_i;
        upd.taken = upd_taken_i;
    end

    assign upd_row = upd.pc[ROW_BITS+1:2];
    assign upd_col = (INSTR_PER_FETCH == 2) ? upd.pc[1] : 1'b0;
    assign lk_row  = vpc_i[ROW_BITS+1:2];
    assign unused_bits = ^{vpc_i[VLEN-1:ROW_BITS+2], vpc_i[1:0],
                           upd.pc[VLEN-1:ROW_BITS+2], upd.pc[0]};

    // A flush seen in IDLE already blocks that cycle's update.
    assign upd_en = upd.valid & ~debug_mode_i & (state_q == BHT_IDLE) & ~flush_i;

    always_comb begin
        entry_d.valid = 1'b1;
        if (table_q[upd_row][upd_col].valid) begin
            entry_d.sat = bht_sat_next(table_q[upd_row][upd_col].sat, upd.taken);
        end else begin
            entry_d.sat = upd.taken ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            BHT_IDLE: begin
                if (flush_i) begin
                    state_d = BHT_SWEEP;
                    cnt_d   = '0;
                end
            end
            BHT_SWEEP: begin
                if (flush_i) begin
                    cnt_d = '0;
                end else if (cnt_q == ROW_BITS'(NR_ROWS - 1)) begin
                    state_d = BHT_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = BHT_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        for (int unsigned c = 0; c < INSTR_PER_FETCH; c++) begin
            pred_d[c].valid = table_q[lk_row][c].valid & (state_q != BHT_SWEEP);
            pred_d[c].taken = table_q[lk_row][c].sat[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BHT_IDLE;
            cnt_q   <= '0;
            for (int unsigned c = 0; c < INSTR_PER_FETCH; c++) begin
                pred_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pred_q  <= pred_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NR_ROWS; r++) begin
                for (int unsigned c = 0; c < INSTR_PER_FETCH; c++) begin
                    table_q[r][c] <= '0;
                end
            end
        end else if (state_q == BHT_SWEEP) begin
            for (int unsigned c = 0; c < INSTR_PER_FETCH; c++) begin
                table_q[cnt_q][c].valid <= 1'b0;
            end
        end else if (upd_en) begin
            table_q[upd_row][upd_col] <= entry_d;
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < INSTR_PER_FETCH; c++) begin
            pred_valid_o[c] = pred_q[c].valid;
            pred_taken_o[c] = pred_q[c].taken;
        end
    end

    assign flush_busy_o = (state_q == BHT_SWEEP);

endmodule

// File: tb/tb_bht_flush_sweep.sv
// Self-checking bench for bht_flush_sweep: directed scenarios plus random
// traffic against a table-level reference model.
module tb_bht_flush_sweep;

    localparam int NROWS = 64;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        dbg;
    logic [63:0] vpc;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic [1:0]  pred_valid_o;
    logic [1:0]  pred_taken_o;
    logic        flush_busy_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counters per (row, slot) and remaining sweep cycles.
    bit         m_valid [NROWS][2];
    logic [1:0] m_sat   [NROWS][2];
    bit         m_busy;
    int         m_left;

    bht_flush_sweep #(
        .NR_ENTRIES(128),
        .INSTR_PER_FETCH(2),
        .VLEN(64)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .flush_i(flush),
        .debug_mode_i(dbg),
        .vpc_i(vpc),
        .upd_valid_i(upd_valid),
        .upd_pc_i(upd_pc),
        .upd_taken_i(upd_taken),
        .pred_valid_o(pred_valid_o),
        .pred_taken_o(pred_taken_o),
        .flush_busy_o(flush_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NROWS; r++) begin
            for (int c = 0; c < 2; c++) begin
                m_valid[r][c] = 1'b0;
                m_sat[r][c]   = 2'b00;
            end
        end
        m_busy = 1'b0;
        m_left = 0;
    endtask

    // One clock: predict from the model, advance the DUT, compare.
    task automatic tick();
        logic [1:0] ev;
        logic [1:0] et;
        int r;
        int ur;
        int uc;
        ev = 2'b00;
        et = 2'b00;
        if (rst) begin
            model_clear();
        end else begin
            r = int'(vpc[7:2]);
            for (int c = 0; c < 2; c++) begin
                ev[c] = m_valid[r][c] && !m_busy;
                et[c] = m_sat[r][c][1];
            end
            if (upd_valid && !dbg && !m_busy && !flush) begin
                ur = int'(upd_pc[7:2]);
                uc = int'(upd_pc[1]);
                if (!m_valid[ur][uc]) begin
                    m_valid[ur][uc] = 1'b1;
                    m_sat[ur][uc]   = upd_taken ? 2'd2 : 2'd1;
                end else if (upd_taken) begin
                    if (m_sat[ur][uc] != 2'd3) m_sat[ur][uc] = m_sat[ur][uc] + 2'd1;
                end else begin
                    if (m_sat[ur][uc] != 2'd0) m_sat[ur][uc] = m_sat[ur][uc] - 2'd1;
                end
            end
            if (m_busy) begin
                if (flush) begin
                    m_left = NROWS;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        for (int rr = 0; rr < NROWS; rr++) begin
                            m_valid[rr][0] = 1'b0;
                            m_valid[rr][1] = 1'b0;
                        end
                    end
                end
            end else if (flush) begin
                m_busy = 1'b1;
                m_left = NROWS;
            end
        end
        @(posedge clk);
        #1;
        check("pred_valid", {62'd0, pred_valid_o}, {62'd0, ev});
        check("pred_taken", {62'd0, pred_taken_o}, {62'd0, et});
        check("flush_busy", {63'd0, flush_busy_o}, {63'd0, m_busy});
    endtask

    task automatic upd(input logic [63:0] pc, input logic tk);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = tk;
        tick();
        upd_valid = 1'b0;
    endtask

    int n;

    initial begin
        rst = 1'b1; flush = 1'b0; dbg = 1'b0; vpc = 64'h8000_0000;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        model_clear();
        tick();
        tick();
        rst = 1'b0;
        check("reset_pv", {62'd0, pred_valid_o}, 64'd0);
        check("reset_pt", {62'd0, pred_taken_o}, 64'd0);
        check("reset_busy", {63'd0, flush_busy_o}, 64'd0);
        tick();
        check("lookup_after_reset_pv", {62'd0, pred_valid_o}, 64'd0);

        // First taken update allocates sat=10 in slot 0 only.
        upd(64'h8000_0004, 1'b1);
        vpc = 64'h8000_0004;
        tick();
        check("first_upd_pv", {62'd0, pred_valid_o}, 64'd1);
        check("first_upd_pt", {62'd0, pred_taken_o}, 64'd1);

        // Slot 1: 10,11,11,11,10 then 01,00.
        for (int i = 0; i < 4; i++) upd(64'h8000_0006, 1'b1);
        upd(64'h8000_0006, 1'b0);
        tick();
        check("train_pv", {62'd0, pred_valid_o}, 64'd3);
        check("train_pt", {62'd0, pred_taken_o}, 64'd3);
        upd(64'h8000_0006, 1'b0);
        upd(64'h8000_0006, 1'b0);
        tick();
        check("untrain_pt", {62'd0, pred_taken_o}, 64'd1);

        // Aliased PC trains the same row/slot 0: 10 -> 01.
        upd(64'h8000_0104, 1'b0);
        tick();
        check("alias_pt", {62'd0, pred_taken_o}, 64'd0);
        check("alias_pv", {62'd0, pred_valid_o}, 64'd3);

        // Single-cycle flush; an update inside the sweep is dropped.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n = 1;
        upd(64'h8000_0010, 1'b1);
        if (flush_busy_o) n++;
        while (flush_busy_o && n < 200) begin
            tick();
            if (flush_busy_o) n++;
        end
        check("sweep_len", n, 64);
        vpc = 64'h8000_0004;
        tick();
        vpc = 64'h8000_0010;
        tick();
        check("post_sweep_pv", {62'd0, pred_valid_o}, 64'd0);

        // Flush again at the 30th sweep cycle restarts the count.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n = 1;
        while (n < 30) begin
            tick();
            if (flush_busy_o) n++;
            else n = 200;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (flush_busy_o) n++;
        while (flush_busy_o && n < 300) begin
            tick();
            if (flush_busy_o) n++;
        end
        check("restart_len", n, 94);

        // Debug mode drops updates.
        dbg = 1'b1;
        for (int i = 0; i < 10; i++) upd(64'h8000_0020, 1'b1);
        dbg = 1'b0;
        vpc = 64'h8000_0020;
        tick();
        tick();
        check("debug_pv", {62'd0, pred_valid_o}, 64'd0);

        // Reset in the middle of a sweep.
        upd(64'h8000_0020, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_sweep_busy", {63'd0, flush_busy_o}, 64'd0);
        tick();
        check("rst_mid_sweep_pv", {62'd0, pred_valid_o}, 64'd0);

        // Random traffic on a small PC set so rows collide often.
        for (int i = 0; i < 2500; i++) begin
            vpc = 64'h8000_0000 | (64'($urandom_range(0, 3)) << 8)
                | (64'($urandom_range(0, 7)) << 2) | (64'($urandom_range(0, 1)) << 1);
            upd_pc = 64'h8000_0000 | (64'($urandom_range(0, 3)) << 8)
                | (64'($urandom_range(0, 7)) << 2) | (64'($urandom_range(0, 1)) << 1);
            upd_valid = ($urandom_range(0, 3) != 0);
            upd_taken = $urandom_range(0, 1) == 1;
            flush     = ($urandom_range(0, 149) == 0);
            dbg       = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 799) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; dbg = 1'b0; upd_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
